// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter with packet locking in front of a single UART.
// Issues one transmit pulse per accepted byte and tracks the UART busy flag.
module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int START_TIMEOUT = 16,
   localparam int IW           = $clog2(NUM_REQ),
   localparam int CW           = $clog2(START_TIMEOUT + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 uart_transmit,
   output logic [7:0]           uart_tx_byte,
   input  logic                 uart_is_transmitting,
   output logic [IW-1:0]        grant_id,
   output logic                 busy,
   output logic                 start_error
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_START,
      WAIT_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] rr_q, rr_d;
   logic          lock_q, lock_d;
   logic [IW-1:0] lock_id_q, lock_id_d;
   logic [7:0]    byte_q, byte_d;
   logic          tx_q, tx_d;
   logic [IW-1:0] grant_q, grant_d;
   logic          err_q, err_d;
   logic          busy_q, busy_d;

   logic [IW-1:0] winner;
   logic          win_ok;
   logic          accept;

   // Locked owner is the sole candidate; otherwise nearest valid after rr_q.
   always_comb begin
      winner = '0;
      win_ok = 1'b0;
      if (lock_q) begin
         winner = lock_id_q;
         win_ok = req_valid[lock_id_q];
      end else begin
         for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
               winner = IW'((int'(rr_q) + k) % NUM_REQ);
               win_ok = 1'b1;
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (!rst && state_q == IDLE && !uart_is_transmitting && win_ok)
         req_ready[winner] = 1'b1;
   end

   assign accept = |req_ready;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rr_d      = rr_q;
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      byte_d    = byte_q;
      tx_d      = 1'b0;
      grant_d   = grant_q;
      err_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               byte_d    = req_data[{winner, 3'b000} +: 8];
               tx_d      = 1'b1;
               grant_d   = winner;
               rr_d      = winner;
               lock_d    = ~req_last[winner];
               lock_id_d = winner;
               cnt_d     = '0;
               state_d   = WAIT_START;
            end
         end
         WAIT_START: begin
            if (uart_is_transmitting) begin
               state_d = WAIT_DONE;
            end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!uart_is_transmitting)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rr_q      <= IW'(NUM_REQ - 1);
         lock_q    <= 1'b0;
         lock_id_q <= '0;
         byte_q    <= '0;
         tx_q      <= 1'b0;
         grant_q   <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rr_q      <= rr_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         byte_q    <= byte_d;
         tx_q      <= tx_d;
         grant_q   <= grant_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
      end
   end

   assign uart_transmit = tx_q;
   assign uart_tx_byte  = byte_q;
   assign grant_id      = grant_q;
   assign busy          = busy_q;
   assign start_error   = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte sources, a UART
// model and a scoreboard of expected (requester, byte) transmissions.
module tb_uart_tx_arbiter;

   localparam int NR    = 4;
   localparam int FRAME = 10;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   req_valid = '0;
   logic [NR*8-1:0] req_data = '0;
   logic [NR-1:0]   req_last = '0;
   logic [NR-1:0]   req_ready;
   logic            uart_transmit;
   logic [7:0]      uart_tx_byte;
   logic            uit = 1'b0;
   logic [1:0]      grant_id;
   logic            busy;
   logic            start_error;

   uart_tx_arbiter #(.NUM_REQ(NR), .START_TIMEOUT(16)) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_data(req_data),
      .req_last(req_last),
      .req_ready(req_ready),
      .uart_transmit(uart_transmit),
      .uart_tx_byte(uart_tx_byte),
      .uart_is_transmitting(uit),
      .grant_id(grant_id),
      .busy(busy),
      .start_error(start_error)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   int exp_q[$];
   int tx_count = 0;
   int err_count = 0;
   int acc[NR] = '{default: 0};

   logic [8:0] mem[NR][16];
   int wr[NR] = '{default: 0};
   int rd[NR] = '{default: 0};
   logic [NR-1:0] xfer = '0;
   logic uit_at_edge = 1'b0;
   bit model_en = 1'b1;
   bit force_busy = 1'b0;
   int frame = 0;

   task automatic check(input string name, input int act, input int want);
      nvec++;
      if (act != want) begin
         nerr++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
      end
   endtask

   always @(posedge clk) begin
      xfer        <= req_valid & req_ready;
      uit_at_edge <= uit;
   end

   // UART model and requester sources, both updated away from the clock edge
   always @(negedge clk) begin
      if (uart_transmit && model_en) frame = FRAME;
      else if (frame > 0) frame--;
      uit = force_busy || (frame > 0);
      for (int i = 0; i < NR; i++) begin
         if (xfer[i]) begin
            rd[i]++;
            acc[i]++;
         end
         req_valid[i] = (rd[i] < wr[i]);
         req_data[i*8 +: 8] = req_valid[i] ? mem[i][rd[i]][7:0] : 8'h00;
         req_last[i] = req_valid[i] ? mem[i][rd[i]][8] : 1'b0;
      end
   end

   int cyc = 0;
   int tx_cyc = 0;
   bit err_prev = 1'b0;

   // Scoreboard monitor
   always @(negedge clk) begin
      int e;
      cyc++;
      if (uart_transmit) begin
         tx_count++;
         tx_cyc = cyc;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
         check("tx_id_byte", int'({grant_id, uart_tx_byte}), e);
         check("tx_while_busy", int'(uit_at_edge), 0);
      end
      if (start_error) begin
         err_count++;
         check("err_delay", cyc - tx_cyc, 16);
         check("err_pulse", int'(err_prev), 0);
      end
      err_prev = start_error;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic load(input int id, input bit last, input logic [7:0] b);
      mem[id][wr[id]] = {last, b};
      wr[id]++;
   endtask

   task automatic expect_tx(input int id, input int b);
      exp_q.push_back(id * 256 + b);
   endtask

   task automatic wait_tx(input int n, input int budget);
      for (int i = 0; i < budget && tx_count < n; i++) step();
      check("wait_tx", tx_count, n);
   endtask

   task automatic wait_quiet(input int budget);
      for (int i = 0; i < budget; i++) begin
         step();
         if (exp_q.size() == 0 && !busy && !uit) break;
      end
      check("quiet_exp", exp_q.size(), 0);
      check("quiet_busy", int'({busy, uit}), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      check("rst_tx", int'(uart_transmit), 0);
      check("rst_byte", int'(uart_tx_byte), 0);
      check("rst_grant", int'(grant_id), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_err", int'(start_error), 0);
      check("rst_ready", int'(req_ready), 0);
      rst = 1'b0;
   endtask

   int base;

   initial begin
      step();
      do_reset();

      // single byte
      expect_tx(0, 8'hA5);
      load(0, 1'b1, 8'hA5);
      wait_tx(1, 20);
      check("t1_grant", int'(grant_id), 0);
      check("t1_busy", int'(busy), 1);
      step();
      check("t1_pulse_len", int'(uart_transmit), 0);
      check("t1_hold", int'(uart_tx_byte), 8'hA5);
      wait_quiet(60);
      check("t1_accepts", acc[0], 1);

      // round robin from reset, requester 3 joins with pointer at 1
      do_reset();
      base = tx_count;
      expect_tx(1, 8'h21); expect_tx(2, 8'h31);
      expect_tx(1, 8'h22); expect_tx(2, 8'h32);
      expect_tx(1, 8'h23); expect_tx(2, 8'h33);
      expect_tx(3, 8'h41);
      for (int i = 0; i < 3; i++) begin
         load(1, 1'b1, 8'(8'h21 + i));
         load(2, 1'b1, 8'(8'h31 + i));
      end
      wait_tx(base + 5, 120);
      load(3, 1'b1, 8'h41);
      wait_quiet(200);

      // packet lock
      expect_tx(0, 8'h10); expect_tx(0, 8'h11);
      expect_tx(0, 8'h12); expect_tx(1, 8'h55);
      load(0, 1'b0, 8'h10);
      load(0, 1'b0, 8'h11);
      load(0, 1'b1, 8'h12);
      load(1, 1'b1, 8'h55);
      wait_quiet(200);

      // start timeout, then recovery
      model_en = 1'b0;
      expect_tx(2, 8'h3C);
      load(2, 1'b1, 8'h3C);
      for (int i = 0; i < 60 && err_count == 0; i++) step();
      check("t4_err_seen", err_count, 1);
      check("t4_idle", int'(busy), 0);
      model_en = 1'b1;
      expect_tx(2, 8'h3D);
      load(2, 1'b1, 8'h3D);
      wait_quiet(60);
      check("t4_err_once", err_count, 1);

      // reset mid-packet during WAIT_DONE
      base = tx_count;
      expect_tx(0, 8'h60);
      load(0, 1'b0, 8'h60);
      wait_tx(base + 1, 20);
      repeat (4) step();
      load(1, 1'b1, 8'h70);
      check("t5_busy", int'(busy), 1);
      expect_tx(1, 8'h70);
      do_reset();
      wait_quiet(80);

      // backpressure from an externally busy UART
      force_busy = 1'b1;
      base = tx_count;
      for (int i = 0; i < NR; i++) load(i, 1'b1, 8'(8'h80 + i));
      expect_tx(2, 8'h82); expect_tx(3, 8'h83);
      expect_tx(0, 8'h80); expect_tx(1, 8'h81);
      repeat (3) step();
      for (int i = 0; i < 8; i++) begin
         step();
         check("t6_ready", int'(req_ready), 0);
         check("t6_tx", int'(uart_transmit), 0);
      end
      check("t6_none", tx_count, base);
      force_busy = 1'b0;
      wait_quiet(200);
      check("t6_all", tx_count, base + 4);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter among NUM_REQ byte-stream requesters using round-robin arbitration with packet locking. A requester marks the final byte of a packet with req_last. Once a requester wins with a non-last byte, it owns the transmitter until that packet ends. The block sequences the UART: it drives a one-cycle transmit pulse with the byte, confirms the UART started, and waits for it to go idle. It sits between on-chip message sources (debug and console producers) and the uart instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
START_TIMEOUT, 16, cycles allowed in WAIT_START for uart_is_transmitting to assert before the byte is declared lost.

Ports:
clk  in  1  master clock
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*8  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NUM_REQ  byte is the last of its packet
req_ready  out  NUM_REQ  byte accepted this cycle (transfer = valid & ready)
uart_transmit  out  1  one-cycle start pulse to the UART
uart_tx_byte  out  8  byte to the UART; held stable until the next accept
uart_is_transmitting  in  1  UART busy flag
grant_id  out  $clog2(NUM_REQ)  requester index of the last accepted byte
busy  out  1  high when state != IDLE
start_error  out  1  one-cycle pulse on start timeout

Behaviour:
- Single clock domain. All state is registered. req_ready is the only combinational output.
- Reset: state=IDLE, uart_transmit=0, uart_tx_byte=0, grant_id=0, rr_ptr=NUM_REQ-1, lock=0, lock_id=0, start_error=0, busy=0, req_ready=0. rst overrides any state, including mid-byte and mid-packet, and clears lock.
- States and transitions:
  - IDLE → WAIT_START on accept.
  - WAIT_START → WAIT_DONE when uart_is_transmitting=1.
  - WAIT_START → IDLE on timeout.
  - WAIT_DONE → IDLE when uart_is_transmitting=0.
- Winner selection in IDLE:
  - If lock=1, the only candidate is lock_id.
  - Otherwise, the first i with req_valid[i] searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
- req_ready[w]=1 only when state=IDLE, uart_is_transmitting=0, w is the winner and req_valid[w]=1. All other bits are 0.
- On accept at edge T:
  - uart_tx_byte←data[w], uart_transmit←1, grant_id←w, rr_ptr←w.
  - lock←~req_last[w], lock_id←w.
  - Timeout counter←0, state←WAIT_START.
- uart_transmit is high for exactly one cycle (T+1) and is forced to 0 otherwise.
- WAIT_START: the counter increments each cycle. uart_is_transmitting=1 moves to WAIT_DONE. Counter reaching START_TIMEOUT-1 with the UART still idle:
  - start_error pulses 1 cycle; state←IDLE.
  - Byte is dropped; lock state is kept as set at accept.
- WAIT_DONE: leave when uart_is_transmitting=0. The next accept is possible one cycle later, in IDLE.
- Throughput: at most one byte per UART frame plus 2 cycles. No byte is ever issued while uart_is_transmitting=1.
- Locked requester drops req_valid mid-packet: the block stays locked and waits indefinitely; other requesters are not served.
- Simultaneous valid from all requesters with lock=0: strict rotation. No requester waits more than NUM_REQ-1 packets.
- req_data, req_last and the valid of a non-granted requester are ignored. A requester must hold data and last stable while valid=1 and ready=0.
- uart_is_transmitting high in IDLE (UART still busy from an external source or after a reset race): no accept until it is low.

Test Plan:
1. Single byte: req_valid[0]=1, data=0xA5, last=1, UART model idle.
   - Required: ready[0] for 1 cycle; uart_transmit=1 the next cycle with uart_tx_byte=0xA5; busy held until the UART frame ends; grant_id=0; lock=0.
2. Round-robin: requesters 1 and 2 each present a continuous stream of single-byte packets (last=1) from reset.
   - Required accept order: 1,2,1,2.
   - Then raise requester 3 while the pointer is at 1; required next grant: 2, then 3.
3. Packet lock: requester 0 sends 3 bytes 0x10,0x11,0x12 (last on 0x12) while requester 1 holds a byte 0x55 valid throughout.
   - Required UART sequence: 0x10,0x11,0x12,0x55.
4. Start timeout: UART model never raises is_transmitting; requester 2 sends 0x3C.
   - Required: start_error pulses exactly 16 cycles after uart_transmit; state returns to IDLE; the next request is accepted.
5. Reset mid-packet: requester 0 sends a non-last byte; assert rst during WAIT_DONE; requester 1 is valid after reset.
   - Required: all outputs at reset values; lock cleared; requester 1 is granted first after the UART idles.
6. Backpressure: hold uart_is_transmitting=1 externally with all req_valid=1.
   - Required: req_ready stays 0 and no transmit pulse until it falls.
